lpc_frame_reader: RTL and testbench

- Sequences the DDR3 read master: one read per analysis frame. Drives the read master control port and drains its 16-bit stream FIFO.
- Presents samples to the LPC algorithm core on a valid/ready stream with frame-last marking.
- Sits directly upstream of the algorithm core and downstream of the read master stream port.

---
 rtl/lpc_fpga_pkg.sv | 38 +++
 rtl/lpc_frame_preemph.sv | 43 ++++
 rtl/lpc_frame_reader.sv | 207 ++++++++++++++++++++
 tb/tb_lpc_frame_reader.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_fpga_pkg.sv
// Shared types and constants for the LPC frame reader.
//   state_e        : frame reader sequencing states
//   SAMPLE_W       : sample width (equals the read master stream width)
//   BYTES_PER_SAMPLE, PREEMPH_SHIFT, ACC_W, SAT_MIN/SAT_MAX : datapath constants
//   sat16()        : clamp an ACC_W signed value into the sample range
package lpc_fpga_pkg;

    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned BYTES_PER_SAMPLE = 2;
    localparam int unsigned PREEMPH_SHIFT    = 5;
    localparam int unsigned ACC_W            = 18;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd32768;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        STREAM,
        WAIT_DONE,
        NEXT,
        FINISH
    } state_e;

    // Clamp a wide signed result into a signed sample.
    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [SAMPLE_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[SAMPLE_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/lpc_frame_preemph.sv
// Pre-emphasis filter y = sat16(x[n] - x[n-1] + (x[n-1] >>> 5)), coefficient 31/32.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : clears x[n-1] (frame start)
//   load       : current x is consumed; it becomes x[n-1]
//   x          : current raw sample
//   y_c        : filtered sample (combinational, same cycle as x)
module lpc_frame_preemph
    import lpc_fpga_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [SAMPLE_W-1:0] x,
    output logic [SAMPLE_W-1:0] y_c
);

    logic signed [SAMPLE_W-1:0] prev_q;
    logic signed [SAMPLE_W-1:0] prev_d;
    logic signed [ACC_W-1:0]    acc_c;

    // Filter arithmetic is done in ACC_W bits so the difference cannot wrap.
    always_comb begin
        prev_d = prev_q;
        if (clr) begin
            prev_d = '0;
        end else if (load) begin
            prev_d = signed'(x);
        end
        acc_c = ACC_W'(signed'(x)) - ACC_W'(prev_q) + ACC_W'(prev_q >>> PREEMPH_SHIFT);
        y_c   = sat16(acc_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/lpc_frame_reader.sv
// Frame reader: issues one DDR3 read-master transfer per analysis frame and
// streams the returned samples to the LPC core on a valid/ready interface.
// Optional build macro LPC_FRAME_READER_PREEMPH_EN inserts a 31/32 pre-emphasis
// filter on the sample path (no added latency).
// Ports:
//   clk_clk, reset_reset_n                  : clock, async active-low reset
//   start, frame_base, frame_stride,
//   frame_len, num_frames                   : job request (latched on accepted start)
//   busy, done, frame_idx                   : job status
//   out_valid, out_ready, out_data, out_last: sample stream to the LPC core
//   rm_*                                    : read master control and stream FIFO
module lpc_frame_reader
    import lpc_fpga_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                start,
    input  logic [31:0]         frame_base,
    input  logic [31:0]         frame_stride,
    input  logic [CNT_W-1:0]    frame_len,
    input  logic [CNT_W-1:0]    num_frames,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    frame_idx,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                out_last,
    output logic                rm_fixed_location,
    output logic [31:0]         rm_read_base,
    output logic [31:0]         rm_read_length,
    output logic                rm_go,
    input  logic                rm_done,
    input  logic                rm_early_done,
    output logic                rm_read_buffer,
    input  logic [SAMPLE_W-1:0] rm_buffer_output_data,
    input  logic                rm_data_available
);

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    frame_idx_q, frame_idx_d;
    logic                out_valid_q, out_valid_d;
    logic [SAMPLE_W-1:0] out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [31:0]         rm_read_base_q, rm_read_base_d;
    logic [31:0]         rm_read_length_q, rm_read_length_d;
    logic                rm_go_q, rm_go_d;
    logic [31:0]         stride_q, stride_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                seen_q, seen_d;

    logic                pop_c;
    logic                launch_c;
    logic [SAMPLE_W-1:0] sample_c;
    logic                unused_c;

    // Early-done and the forced-zero address bit carry no information here.
    assign unused_c = rm_early_done ^ frame_base[0];

    // Pop the show-ahead FIFO only while samples are owed and the output slot frees up.
    assign pop_c    = (state_q == STREAM) && rm_data_available && (remaining_q != '0)
                      && (!out_valid_q || out_ready);
    assign launch_c = (state_q == LAUNCH);

`ifdef LPC_FRAME_READER_PREEMPH_EN
    lpc_frame_preemph u_preemph (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .clr   (launch_c),
        .load  (pop_c),
        .x     (rm_buffer_output_data),
        .y_c   (sample_c)
    );
`else
    assign sample_c = rm_buffer_output_data;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        frame_idx_d      = frame_idx_q;
        out_valid_d      = out_valid_q;
        out_data_d       = out_data_q;
        out_last_d       = out_last_q;
        rm_read_base_d   = rm_read_base_q;
        rm_read_length_d = rm_read_length_q;
        rm_go_d          = 1'b0;
        stride_d         = stride_q;
        len_d            = len_q;
        num_d            = num_q;
        remaining_d      = remaining_q;
        seen_d           = seen_q | rm_done;

        // Output slot: load on pop, otherwise empty it after a handshake.
        if (pop_c) begin
            out_data_d  = sample_c;
            out_valid_d = 1'b1;
            out_last_d  = (remaining_q == CNT_W'(1));
            remaining_d = remaining_q - CNT_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                seen_d = 1'b0;
                if (start) begin
                    stride_d         = frame_stride;
                    len_d            = frame_len;
                    num_d            = num_frames;
                    rm_read_base_d   = {frame_base[31:1], 1'b0};
                    rm_read_length_d = 32'(frame_len) * 32'(BYTES_PER_SAMPLE);
                    frame_idx_d      = '0;
                    busy_d           = 1'b1;
                    state_d          = ((frame_len == '0) || (num_frames == '0)) ? FINISH : LAUNCH;
                end
            end
            LAUNCH: begin
                rm_go_d     = 1'b1;
                remaining_d = len_q;
                state_d     = STREAM;
            end
            STREAM: begin
                if (remaining_q == '0) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if ((seen_q || rm_done) && !out_valid_q) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                seen_d         = 1'b0;
                rm_read_base_d = rm_read_base_q + stride_q;
                frame_idx_d    = frame_idx_q + CNT_W'(1);
                state_d        = ((frame_idx_q + CNT_W'(1)) == num_q) ? FINISH : LAUNCH;
            end
            FINISH: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                frame_idx_d = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q          <= IDLE;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            frame_idx_q      <= '0;
            out_valid_q      <= 1'b0;
            out_data_q       <= '0;
            out_last_q       <= 1'b0;
            rm_read_base_q   <= '0;
            rm_read_length_q <= '0;
            rm_go_q          <= 1'b0;
            stride_q         <= '0;
            len_q            <= '0;
            num_q            <= '0;
            remaining_q      <= '0;
            seen_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            frame_idx_q      <= frame_idx_d;
            out_valid_q      <= out_valid_d;
            out_data_q       <= out_data_d;
            out_last_q       <= out_last_d;
            rm_read_base_q   <= rm_read_base_d;
            rm_read_length_q <= rm_read_length_d;
            rm_go_q          <= rm_go_d;
            stride_q         <= stride_d;
            len_q            <= len_d;
            num_q            <= num_d;
            remaining_q      <= remaining_d;
            seen_q           <= seen_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign frame_idx         = frame_idx_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_last          = out_last_q;
    assign rm_read_base      = rm_read_base_q;
    assign rm_read_length    = rm_read_length_q;
    assign rm_go             = rm_go_q;
    assign rm_read_buffer    = pop_c;
    assign rm_fixed_location = 1'b0;

endmodule

// File: tb/tb_lpc_frame_reader.sv
// Self-checking bench for lpc_frame_reader: a memory-backed read master model
// feeds the DUT, and expected samples are derived from the job description.
module tb_lpc_frame_reader;

    localparam int unsigned MEM_WORDS = 4096;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        start;
    logic [31:0] frame_base;
    logic [31:0] frame_stride;
    logic [15:0] frame_len;
    logic [15:0] num_frames;
    logic        busy;
    logic        done;
    logic [15:0] frame_idx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        rm_fixed_location;
    logic [31:0] rm_read_base;
    logic [31:0] rm_read_length;
    logic        rm_go;
    logic        rm_done;
    logic        rm_early_done;
    logic        rm_read_buffer;
    logic [15:0] rm_buffer_output_data;
    logic        rm_data_available;

    lpc_frame_reader dut (
        .clk_clk               (clk_clk),
        .reset_reset_n         (reset_reset_n),
        .start                 (start),
        .frame_base            (frame_base),
        .frame_stride          (frame_stride),
        .frame_len             (frame_len),
        .num_frames            (num_frames),
        .busy                  (busy),
        .done                  (done),
        .frame_idx             (frame_idx),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_data              (out_data),
        .out_last              (out_last),
        .rm_fixed_location     (rm_fixed_location),
        .rm_read_base          (rm_read_base),
        .rm_read_length        (rm_read_length),
        .rm_go                 (rm_go),
        .rm_done               (rm_done),
        .rm_early_done         (rm_early_done),
        .rm_read_buffer        (rm_read_buffer),
        .rm_buffer_output_data (rm_buffer_output_data),
        .rm_data_available     (rm_data_available)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [15:0] idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_go[$];
    logic [15:0] fifo[$];
    logic [15:0] mem [MEM_WORDS];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          job_len;
    logic [31:0] job_len_bytes;
    bit          src_active;
    bit          src_fast;
    int          src_rate;
    int          src_left;
    int          done_delay;
    logic [31:0] src_addr;
    int          ready_mode;
    bit          prev_stall;
    logic [15:0] stall_data;
    logic        stall_last;
    int          hs_count;
    int          done_count;
    int          go_count;
    int          last_hs_cyc;
    int          done_cyc;
    bit          consec_check;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 1) % 32'(MEM_WORDS));
    endfunction

    // Reference: per frame, base + f*stride, samples at consecutive halfword addresses.
    task automatic build_expected(input logic [31:0] base, input logic [31:0] stride,
                                  input int len, input int n);
        logic [31:0] fb;
        int          prev;
        int          x;
        int          y;
        exp_t        e;
        if (len == 0) return;
        fb = {base[31:1], 1'b0};
        for (int f = 0; f < n; f++) begin
            exp_go.push_back(fb);
            prev = 0;
            for (int i = 0; i < len; i++) begin
                x = int'($signed(mem[widx(fb + 32'(2 * i))]));
`ifdef LPC_FRAME_READER_PREEMPH_EN
                y = x - prev + (prev >>> 5);
                if (y > 32767) y = 32767;
                else if (y < -32768) y = -32768;
`else
                y = x;
`endif
                prev   = x;
                e.data = 16'(y);
                e.last = (i == len - 1);
                e.idx  = 16'(f);
                exp_q.push_back(e);
            end
            fb = fb + stride;
        end
    endtask

    task automatic check_reset_values();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_frame_idx", 64'(frame_idx), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_rm_go", 64'(rm_go), 64'(0));
        check("rst_rm_read_base", 64'(rm_read_base), 64'(0));
        check("rst_rm_read_length", 64'(rm_read_length), 64'(0));
        check("rst_rm_read_buffer", 64'(rm_read_buffer), 64'(0));
        check("rst_fixed_location", 64'(rm_fixed_location), 64'(0));
    endtask

    // One clock of environment: observe just after negedge, then model the read master.
    task automatic tick();
        bit          pop;
        bit          go;
        logic [31:0] go_base;
        logic [31:0] gexp;
        logic [15:0] tmp16;
        exp_t        e;
        #1;
        if (prev_stall) begin
            check("stall_valid_hold", 64'(out_valid), 64'(1));
            check("stall_data_hold", 64'(out_data), 64'(stall_data));
            check("stall_last_hold", 64'(out_last), 64'(stall_last));
        end
        if (out_valid && out_ready) begin
            hs_count++;
            check("sample_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_last", 64'(out_last), 64'(e.last));
                check("frame_idx", 64'(frame_idx), 64'(e.idx));
            end
            if (consec_check && hs_count > 1)
                check("back_to_back_gap", 64'(cyc - last_hs_cyc), 64'(1));
            last_hs_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        if (prev_stall) begin
            check("no_pop_while_stalled", 64'(rm_read_buffer), 64'(0));
            stall_data = out_data;
            stall_last = out_last;
        end
        if (rm_read_buffer)
            check("pop_when_available", 64'(fifo.size() != 0), 64'(1));
        pop     = rm_read_buffer;
        go      = rm_go;
        go_base = rm_read_base;
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (go) begin
            go_count++;
            check("go_expected", 64'(exp_go.size() != 0), 64'(1));
            if (exp_go.size() != 0) begin
                gexp = exp_go.pop_front();
                check("rm_read_base", 64'(rm_read_base), 64'(gexp));
            end
            check("rm_read_length", 64'(rm_read_length), 64'(job_len_bytes));
            check("rm_fixed_location", 64'(rm_fixed_location), 64'(0));
        end

        @(posedge clk_clk);
        @(negedge clk_clk);
        cyc++;
        start   = 1'b0;
        rm_done = 1'b0;
        if (pop && fifo.size() != 0) tmp16 = fifo.pop_front();
        if (go) begin
            src_active = 1'b1;
            src_addr   = go_base;
            src_left   = job_len;
            done_delay = $urandom_range(0, 4);
        end else if (src_active) begin
            if (src_left > 0) begin
                if (src_fast) begin
                    while (src_left > 0) begin
                        fifo.push_back(mem[widx(src_addr)]);
                        src_addr += 32'd2;
                        src_left--;
                    end
                end else if ($urandom_range(0, 99) < src_rate) begin
                    fifo.push_back(mem[widx(src_addr)]);
                    src_addr += 32'd2;
                    src_left--;
                end
            end else if (done_delay > 0) begin
                done_delay--;
            end else begin
                rm_done    = 1'b1;
                src_active = 1'b0;
            end
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        rm_early_done         = 1'($urandom_range(0, 1));
        rm_data_available     = (fifo.size() != 0);
        rm_buffer_output_data = (fifo.size() != 0) ? fifo[0] : 16'h0;
    endtask

    task automatic run_job(input logic [31:0] base, input logic [31:0] stride,
                           input int len, input int n, input bit poke_start);
        int d0;
        bit seen;
        build_expected(base, stride, len, n);
        job_len       = len;
        job_len_bytes = 32'(len * 2);
        d0            = done_count;
        hs_count      = 0;
        frame_base    = base;
        frame_stride  = stride;
        frame_len     = 16'(len);
        num_frames    = 16'(n);
        start         = 1'b1;
        tick();
        check("busy_after_start", 64'(busy), 64'(1));
        frame_base   = $urandom;
        frame_stride = $urandom;
        frame_len    = 16'($urandom_range(1, 9));
        num_frames   = 16'($urandom_range(1, 9));
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (poke_start && k == 2) start = 1'b1;
            tick();
            if (done_count != d0) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'(1));
        tick();
        tick();
        check("single_done", 64'(done_count - d0), 64'(1));
        check("samples_left", 64'(exp_q.size()), 64'(0));
        check("launches_left", 64'(exp_go.size()), 64'(0));
        check("busy_after_done", 64'(busy), 64'(0));
    endtask

    initial begin
        int g0;
        int start_cyc;
        reset_reset_n         = 1'b0;
        start                 = 1'b0;
        frame_base            = '0;
        frame_stride          = '0;
        frame_len             = '0;
        num_frames            = '0;
        out_ready             = 1'b1;
        rm_done               = 1'b0;
        rm_early_done         = 1'b0;
        rm_buffer_output_data = '0;
        rm_data_available     = 1'b0;
        src_active = 1'b0; src_fast = 1'b1; src_rate = 100;
        ready_mode = 0; prev_stall = 1'b0; consec_check = 1'b0;
        hs_count = 0; done_count = 0; go_count = 0; last_hs_cyc = 0; done_cyc = 0;
        job_len = 0; job_len_bytes = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 16'($urandom);

        repeat (3) @(negedge clk_clk);
        check_reset_values();
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // Single frame, back-to-back, values 1..4.
        for (int i = 0; i < 4; i++) mem[widx(32'h1000) + i] = 16'(i + 1);
        consec_check = 1'b1;
        run_job(32'h0000_1000, 32'h0, 4, 1, 1'b0);
        consec_check = 1'b0;

        // Multi-frame stepping of the base address.
        run_job(32'h0000_0000, 32'h0000_0100, 2, 3, 1'b0);

        // Backpressure pattern 1,0,0,1 with a full FIFO; start pulsed while busy.
        ready_mode = 1;
        run_job(32'h0000_0401, 32'h0000_0010, 6, 2, 1'b1);

        // Address wrap across 2^32.
        ready_mode = 2;
        run_job(32'hFFFF_FFF0, 32'h0000_0020, 3, 2, 1'b0);

        // Zero-length job: no launch, done two cycles after start.
        ready_mode = 0;
        g0 = go_count;
        start_cyc = cyc;
        run_job(32'h0000_0800, 32'h0000_0040, 0, 5, 1'b0);
        check("zero_job_done_latency", 64'(done_cyc - start_cyc), 64'(2));
        check("zero_job_no_go", 64'(go_count - g0), 64'(0));

`ifdef LPC_FRAME_READER_PREEMPH_EN
        // Saturation and per-frame history clear.
        mem[widx(32'h3000)]     = 16'd1000;
        mem[widx(32'h3000) + 1] = 16'd1000;
        mem[widx(32'h3000) + 2] = 16'h8000;
        run_job(32'h0000_3000, 32'h0, 3, 2, 1'b0);
`endif

        // Reset in the middle of streaming.
        ready_mode = 0; src_fast = 1'b1;
        build_expected(32'h0000_2000, 32'h0, 4, 1);
        job_len = 4; job_len_bytes = 32'd8; hs_count = 0;
        frame_base = 32'h0000_2000; frame_stride = '0; frame_len = 16'd4; num_frames = 16'd1;
        start = 1'b1;
        tick();
        for (int k = 0; k < 200 && hs_count < 2; k++) tick();
        check("reached_two_samples", 64'(hs_count), 64'(2));
        #2 reset_reset_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk_clk);
        @(negedge clk_clk);
        exp_q.delete(); exp_go.delete(); fifo.delete();
        src_active = 1'b0; prev_stall = 1'b0; rm_done = 1'b0;
        rm_data_available = 1'b0; rm_buffer_output_data = '0;
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        run_job(32'h0000_2000, 32'h0000_0002, 4, 2, 1'b0);

        // Randomized jobs with random backpressure and source rate.
        ready_mode = 2;
        for (int j = 0; j < 6; j++) begin
            src_fast = 1'($urandom_range(0, 1));
            src_rate = $urandom_range(30, 100);
            run_job($urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64) * 2),
                    $urandom_range(1, 8), $urandom_range(1, 4), 1'(j % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
